// File: rtl/reg_file_mp.sv
// Multi-read-port register file: one write port, NUM_RD registered read ports with write-first
// forwarding, and a sequential clear engine. Optional macro RF_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_mp #(
    parameter  int unsigned BW     = 16,
    parameter  int unsigned DEPTH  = 32,
    parameter  int unsigned NUM_RD = 2,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 chip_en,
    input  logic                 write_en_n,
    input  logic [AW-1:0]        write_addr,
    input  logic [BW-1:0]        data_in,
    input  logic [NUM_RD*AW-1:0] read_addr,
    output logic [NUM_RD*BW-1:0] data_out,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 write_err
);

    // Encoding keeps busy and clear_done as direct flop bits.
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_CLEAR = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [AW-1:0]        r_cnt;
    logic [BW-1:0]        r_mem [DEPTH];
    logic [NUM_RD*BW-1:0] r_data_out;
    logic [NUM_RD*BW-1:0] w_rd_data;
    logic                 r_write_err;
    logic                 w_busy;
    logic                 w_clr_last;
    logic                 w_wr_req;
    logic                 w_wa_ok;
    logic                 w_wa_zero;
    logic                 w_wr_acc;

    assign w_busy     = r_state[0];
    assign w_clr_last = (r_cnt == AW'(DEPTH - 1));
    assign w_wr_req   = chip_en & ~write_en_n;
    assign w_wa_ok    = ({1'b0, write_addr} < (AW+1)'(DEPTH));
`ifdef RF_ZERO_REG_EN
    assign w_wa_zero  = (write_addr == '0);
`else
    assign w_wa_zero  = 1'b0;
`endif
    assign w_wr_acc   = w_wr_req & ~w_busy & w_wa_ok & ~w_wa_zero;

    assign busy       = r_state[0];
    assign clear_done = r_state[1];
    assign write_err  = r_write_err;
    assign data_out   = r_data_out;

    // Clear FSM state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear FSM next state; requests outside IDLE are dropped
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear address counter
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) && clear_req) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= w_clr_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Storage array; clear and write never coincide because writes are blocked while busy
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_busy && (r_cnt == AW'(i))) begin
                    r_mem[i] <= '0;
                end else if (w_wr_acc && (write_addr == AW'(i))) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    // Per-port read mux with write-first forwarding and in-flight clear masking
    always_comb begin
        logic [AW-1:0] ra;
        logic          rd_zero;
        ra        = '0;
        rd_zero   = 1'b0;
        w_rd_data = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            ra = read_addr[k*AW +: AW];
`ifdef RF_ZERO_REG_EN
            rd_zero = (ra == '0);
`else
            rd_zero = 1'b0;
`endif
            if (w_wr_acc && (ra == write_addr)) begin
                w_rd_data[k*BW +: BW] = data_in;
            end else if (({1'b0, ra} < (AW+1)'(DEPTH)) && !(w_busy && (ra == r_cnt)) && !rd_zero) begin
                w_rd_data[k*BW +: BW] = r_mem[ra];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out  <= '0;
            r_write_err <= 1'b0;
        end else begin
            if (chip_en) begin
                r_data_out <= w_rd_data;
            end
            r_write_err <= w_wr_req & w_busy & ~w_wa_zero;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (BW=16, DEPTH=32, NUM_RD=2).
module tb_reg_file_mp;

    localparam int unsigned BW     = 16;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned AW     = 5;

    logic                 clock = 1'b0;
    logic                 rst_n;
    logic                 chip_en;
    logic                 write_en_n;
    logic [AW-1:0]        write_addr;
    logic [BW-1:0]        data_in;
    logic [NUM_RD*AW-1:0] read_addr;
    logic [NUM_RD*BW-1:0] data_out;
    logic                 clear_req;
    logic                 busy;
    logic                 clear_done;
    logic                 write_err;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_mp #(.BW(BW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .chip_en    (chip_en),
        .write_en_n (write_en_n),
        .write_addr (write_addr),
        .data_in    (data_in),
        .read_addr  (read_addr),
        .data_out   (data_out),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .write_err  (write_err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
        chip_en    = 1'b1;
        write_en_n = 1'b0;
        write_addr = a;
        data_in    = d;
        tick();
        write_en_n = 1'b1;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        chip_en   = 1'b1;
        read_addr = {a1, a0};
        tick();
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_idx;
        logic [15:0] exp0;
        logic [15:0] exp1;

        rst_n      = 1'b0;
        chip_en    = 1'b0;
        write_en_n = 1'b1;
        write_addr = '0;
        data_in    = '0;
        read_addr  = '0;
        clear_req  = 1'b0;

        @(negedge clock);
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_clear_done", 32'(clear_done), 32'h0);
        check("rst_write_err",  32'(write_err),  32'h0);
        rst_n = 1'b1;
        tick();

        // basic write then dual-port read
        read_addr = {5'd1, 5'd1};
        wr(5'd5, 16'hBEEF);
        wr(5'd31, 16'h1234);
        rd2(5'd5, 5'd31);
        check("rd_p0_addr5",  32'(data_out[15:0]),  32'hBEEF);
        check("rd_p1_addr31", 32'(data_out[31:16]), 32'h1234);

        // same-cycle write/read forwarding on port 0
        read_addr  = {5'd5, 5'd7};
        chip_en    = 1'b1;
        write_en_n = 1'b0;
        write_addr = 5'd7;
        data_in    = 16'hA5A5;
        tick();
        write_en_n = 1'b1;
        check("fwd_p0",    32'(data_out[15:0]),  32'hA5A5);
        check("fwd_p1_rd", 32'(data_out[31:16]), 32'hBEEF);

        // chip_en low: outputs hold, write ignored
        chip_en    = 1'b0;
        write_en_n = 1'b0;
        write_addr = 5'd5;
        data_in    = 16'h1111;
        read_addr  = {5'd31, 5'd31};
        tick();
        read_addr  = {5'd0, 5'd2};
        tick();
        check("hold_p0", 32'(data_out[15:0]),  32'hA5A5);
        check("hold_p1", 32'(data_out[31:16]), 32'hBEEF);
        write_en_n = 1'b1;
        rd2(5'd31, 5'd5);
        check("resume_p0",        32'(data_out[15:0]),  32'h1234);
        check("no_write_ce_low",  32'(data_out[31:16]), 32'hBEEF);

        // register 0 behaviour
        wr(5'd0, 16'hFFFF);
        rd2(5'd0, 5'd0);
`ifdef RF_ZERO_REG_EN
        check("reg0_read", 32'(data_out[15:0]), 32'h0);
`else
        check("reg0_read", 32'(data_out[15:0]), 32'hFFFF);
`endif

        // fill the whole array
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr(AW'(i), 16'h1000 | 16'(i));
        end
        rd2(5'd17, 5'd25);
        check("fill_p0", 32'(data_out[15:0]),  32'h1011);
        check("fill_p1", 32'(data_out[31:16]), 32'h1019);

        // full clear with a blocked write, an ignored request and a read of the row being cleared
        busy_cnt  = 0;
        done_cnt  = 0;
        done_idx  = -1;
        read_addr = {5'd1, 5'd1};
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int j = 0; j < 35; j++) begin
            if (busy) busy_cnt++;
            if (clear_done) begin
                done_cnt++;
                done_idx = j;
            end
            if (j == 4)  check("werr_pulse", 32'(write_err), 32'h1);
            if (j == 5)  check("werr_once",  32'(write_err), 32'h0);
            if (j == 11) begin
                check("rd_row_clearing", 32'(data_out[15:0]),  32'h0);
                check("rd_row_pending",  32'(data_out[31:16]), 32'h1019);
            end
            write_en_n = 1'b1;
            clear_req  = 1'b0;
            case (j)
                3: begin
                    write_en_n = 1'b0;
                    write_addr = 5'd20;
                    data_in    = 16'h7777;
                end
                5:  clear_req = 1'b1;
                10: read_addr = {5'd25, 5'd10};
                11: read_addr = {5'd1, 5'd1};
                32: begin
                    write_en_n = 1'b0;
                    write_addr = 5'd3;
                    data_in    = 16'h3333;
                end
                default: ;
            endcase
            tick();
        end
        write_en_n = 1'b1;
        check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clear_done_count",  32'(done_cnt), 32'd1);
        check("clear_done_cycle",  32'(done_idx), 32'd32);
        check("idle_after_clear",  32'(busy),     32'h0);
        for (int a = 0; a < int'(DEPTH); a += 2) begin
            rd2(AW'(a), AW'(a + 1));
            exp0 = (a == 3)     ? 16'h3333 : 16'h0;
            exp1 = (a + 1 == 3) ? 16'h3333 : 16'h0;
            check($sformatf("post_clear_r%0d", a),     32'(data_out[15:0]),  32'(exp0));
            check($sformatf("post_clear_r%0d", a + 1), 32'(data_out[31:16]), 32'(exp1));
        end

        // reset in the middle of a clear
        wr(5'd2, 16'hABCD);
        wr(5'd30, 16'hABCE);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        check("midclear_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",     32'(busy),       32'h0);
        check("abort_data_out", 32'(data_out),   32'h0);
        @(negedge clock);
        rst_n    = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (clear_done) done_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_busy", 32'(busy_cnt), 32'd0);
        rd2(5'd2, 5'd30);
        check("abort_r2",  32'(data_out[15:0]),  32'h0);
        check("abort_r30", 32'(data_out[31:16]), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
